// File: rtl/cordic_pkg.sv
// Shared constants and scheduler state encoding for the
// CORDIC rotation front-end.
package cordic_pkg;

  localparam int ANGLE_WIDTH = 22;
  localparam int ITERATIONS  = 16;

  localparam logic signed [ANGLE_WIDTH-1:0] ANG_P90 = 22'sd1647099;
  localparam logic signed [ANGLE_WIDTH-1:0] ANG_M90 = -22'sd1647099;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } sched_state_t;

endpackage

// File: rtl/cordic_rotate_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request found
// searching cyclically upward from the pointer.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      logic [IW-1:0] kk;
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IW'(k);
      if (req[kk]) begin
        gnt     = '0;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/cordic_rotate_sched.sv
// Round-robin scheduler sharing one CORDIC rotate engine.
// Optional BUSY watchdog: define CORDIC_SCHED_TIMEOUT_EN.
module cordic_rotate_sched
  import cordic_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int DATA_WIDTH     = 7,
  parameter  int ANGLE_WIDTH    = cordic_pkg::ANGLE_WIDTH,
  parameter  int TIMEOUT_CYCLES = 32,
  localparam int IW             = $clog2(N_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [N_REQ*DATA_WIDTH-1:0]  i_x,
  input  logic [N_REQ*DATA_WIDTH-1:0]  i_y,
  input  logic [N_REQ*ANGLE_WIDTH-1:0] i_angle,
  output logic [N_REQ-1:0]             o_gnt,
  output logic                         o_res_valid,
  output logic [IW-1:0]                o_res_id,
  output logic [DATA_WIDTH-1:0]        o_res_x,
  output logic [DATA_WIDTH-1:0]        o_res_y,
  output logic                         o_res_err,
  output logic                         o_busy,
  output logic                         o_eng_start,
  output logic [DATA_WIDTH-1:0]        o_eng_x,
  output logic [DATA_WIDTH-1:0]        o_eng_y,
  output logic [ANGLE_WIDTH-1:0]       o_eng_angle,
  input  logic                         i_eng_done,
  input  logic [DATA_WIDTH-1:0]        i_eng_x,
  input  logic [DATA_WIDTH-1:0]        i_eng_y
);

  sched_state_t state_q, state_d;

  logic [IW-1:0]          ptr_q, id_q, res_id_q, pick_idx;
  logic [N_REQ-1:0]       pick_gnt, gnt_q;
  logic [DATA_WIDTH-1:0]  x_q, y_q, res_x_q, res_y_q;
  logic [ANGLE_WIDTH-1:0] ang_q;
  logic                   start_q, vld_q;
  logic                   any_req, tmo, finish;

  assign any_req = |i_req;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q != BUSY) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A done arriving on the final watchdog cycle still wins.
  assign tmo = (state_q == BUSY) && !i_eng_done
            && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (finish) begin
      err_q <= tmo;
    end
  end

  assign o_res_err = err_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign tmo       = 1'b0;
  assign o_res_err = 1'b0;
`endif

  assign finish = (state_q == BUSY) && (i_eng_done || tmo);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (i_eng_done || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      res_id_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ang_q    <= '0;
      res_x_q  <= '0;
      res_y_q  <= '0;
      gnt_q    <= '0;
      start_q  <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= '0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      if (state_q == IDLE && any_req) begin
        id_q    <= pick_idx;
        x_q     <= i_x[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        y_q     <= i_y[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        ang_q   <= i_angle[pick_idx*ANGLE_WIDTH +: ANGLE_WIDTH];
        gnt_q   <= pick_gnt;
        start_q <= 1'b1;
      end
      if (finish) begin
        vld_q    <= 1'b1;
        res_id_q <= id_q;
        res_x_q  <= tmo ? '0 : i_eng_x;
        res_y_q  <= tmo ? '0 : i_eng_y;
      end
      if (state_q == RESP) begin
        ptr_q <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

  assign o_gnt       = gnt_q;
  assign o_eng_start = start_q;
  assign o_res_valid = vld_q;
  assign o_res_id    = res_id_q;
  assign o_res_x     = res_x_q;
  assign o_res_y     = res_y_q;
  assign o_busy      = (state_q != IDLE);
  assign o_eng_x     = x_q;
  assign o_eng_y     = y_q;
  assign o_eng_angle = ang_q;

endmodule
